histogram_cdf_writer: RTL and testbench
=======================================

# histogram_cdf_writer

Downstream stage of the histogram datapath. After the histogram pass has written all 64 scratch-memory lines (256 bins, four 32-bit counters per 128-bit line), this block reads the lines in ascending order, computes the cumulative distribution (running prefix sum over bins 0..255) and writes it to output memory with the same packing. It is started by the histogram controller once `all_lines_written` is seen, and reports completion with a one-cycle `done` pulse.

## Interface
- `NUM_LINES`, 64, scratch lines to process; 4 bins per line.
- `OUT_BASE_ADDRESS`, 16'd0, output-memory address of CDF line 0.
- `clock` input 1 clock.
- `reset` input 1 reset, synchronous, active-high.
- `start` input 1 begin a pass; sampled only in IDLE.
- `scratch_memory_address_pointer` output 16 scratch read address; reset 0.
- `scratch_memory_rdata` input 128 scratch read data, valid one cycle after the address is presented.
- `output_memory_write_enable` output 1 write strobe; reset 0.
- `output_memory_address` output 16 write address; reset 0.
- `output_memory_wdata` output 128 CDF line; reset 0.
- `busy` output 1 pass in progress; reset 0.
- `done` output 1 one-cycle pulse after the last write; reset 0.
- `total_count` output 32 final running total, held until the next accepted `start`; reset 0.

## Operation
- Bin packing (input and output): bin 4k+0 in [127:96], 4k+1 in [95:64], 4k+2 in [63:32], 4k+3 in [31:0] of line k.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: `start`=1 moves to READ, clears the running total, and sets the read address to 0.
  - READ: issues addresses 0..NUM_LINES-1 on consecutive cycles. After the last address, moves to DRAIN.
  - DRAIN: waits for the last two pipeline stages to empty, then moves to DONE.
  - DONE: pulses `done` for one cycle, latches `total_count`, and returns to IDLE.
- Per line, with run = running total before the line:
  - c0 = run+b0, c1 = c0+b1, c2 = c1+b2, c3 = c2+b3.
  - The line writes {c0,c1,c2,c3}; run then becomes c3.
- All sums are 32-bit, modulo 2^32. There is no saturation and no overflow flag.
- The scratch address holds its last value (NUM_LINES-1) after READ.
- Write address is OUT_BASE_ADDRESS+k, with 16-bit wrap.
- `output_memory_address` and `output_memory_wdata` keep their last values while `output_memory_write_enable` is 0.
- `start` outside IDLE is ignored. There is no queuing.
- When `reset` and `start` are both high, reset wins.
- Reset mid-pass: on the next edge every output returns to its reset value and the state returns to IDLE. No write is issued afterward; the partially written output memory is not repaired.

## Timing
- Let T0 be the cycle in which `start` is sampled in IDLE.
- T1..T64: `busy`=1; address k is presented in cycle T1+k.
- T2..T65: `scratch_memory_rdata` for line k arrives in T2+k; the prefix sum is computed and registered.
- T3..T66: `output_memory_write_enable`=1 with line k in cycle T3+k, giving 64 back-to-back writes with no gaps.
- `busy` stays high through T66 and is 0 in T67.
- T67: `done`=1 and `total_count` is valid. The earliest next `start` is accepted in T68.
- Total latency from `start` to `done` is NUM_LINES+3 cycles.

## Structure
- `histogram_pkg` holds the shared definitions:
  - constants BINS_PER_LINE=4, BIN_WIDTH=32, LINE_WIDTH=128, NUM_LINES=64;
  - the FSM state typedef;
  - the bin slice-index constants, shared with the histogram datapath.
- One sub-module, `histogram_line_prefix_sum`:
  - combinational;
  - inputs: 128-bit line and 32-bit carry-in;
  - outputs: 128-bit CDF line and 32-bit carry-out;
  - instantiated once, feeding the registered write stage.

## Test plan
- All-zero scratch memory, `start` at T0 -> 64 writes of 128'h0 in T3..T66, `done` in T67, `total_count`=0.
- Line 0 = {32'd1,0,0,0}, all other lines 0 -> every written word is 1 in all four slots, `total_count`=1.
- Every bin = 1 -> line k = {4k+1, 4k+2, 4k+3, 4k+4}, last line = {253,254,255,256}, `total_count`=256.
- Wrap case: bin0 = 32'hFFFFFFFF, bin1 = 2, all others 0 -> line 0 = {FFFFFFFF,1,1,1}, lines 1..63 all 1, `total_count`=1.
- `reset` asserted in T20 -> write enable 0, `busy` 0 and `done` 0 from T21 with no further writes. A new `start` then gives a full, correct 64-line pass.
- `start` pulsed at T10 and T40 during a pass -> both ignored. A second `start` after `done` with different data -> `total_count` reflects only the new data, with no carry from the previous pass.

Source files
------------

// File: rtl/histogram_pkg.sv
// Shared definitions for the histogram datapath: line geometry, bin slice
// positions within a 128-bit line, and the CDF writer state encoding.
package histogram_pkg;

    localparam int unsigned BINS_PER_LINE = 4;
    localparam int unsigned BIN_WIDTH     = 32;
    localparam int unsigned LINE_WIDTH    = 128;
    localparam int unsigned NUM_LINES     = 64;

    // Bin 4k+0 occupies the most significant word of line k.
    localparam int unsigned BIN0_LSB = 96;
    localparam int unsigned BIN1_LSB = 64;
    localparam int unsigned BIN2_LSB = 32;
    localparam int unsigned BIN3_LSB = 0;
    localparam int unsigned BIN0_MSB = BIN0_LSB + BIN_WIDTH - 1;
    localparam int unsigned BIN1_MSB = BIN1_LSB + BIN_WIDTH - 1;
    localparam int unsigned BIN2_MSB = BIN2_LSB + BIN_WIDTH - 1;
    localparam int unsigned BIN3_MSB = BIN3_LSB + BIN_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } cdf_state_t;

endpackage

// File: rtl/histogram_cdf_writer_if.sv
// Memory-side bus of the CDF writer: scratch read port and output write port.
interface histogram_cdf_writer_if;
    import histogram_pkg::*;

    logic [15:0]           scratch_memory_address_pointer;
    logic [LINE_WIDTH-1:0] scratch_memory_rdata;
    logic                  output_memory_write_enable;
    logic [15:0]           output_memory_address;
    logic [LINE_WIDTH-1:0] output_memory_wdata;

    modport master (
        output scratch_memory_address_pointer,
        input  scratch_memory_rdata,
        output output_memory_write_enable,
        output output_memory_address,
        output output_memory_wdata
    );

    modport slave (
        input  scratch_memory_address_pointer,
        output scratch_memory_rdata,
        input  output_memory_write_enable,
        input  output_memory_address,
        input  output_memory_wdata
    );

endinterface

// File: rtl/histogram_line_prefix_sum.sv
// Running prefix sum across the four bins of one line, seeded by carry_in.
module histogram_line_prefix_sum
    import histogram_pkg::*;
(
    input  logic [LINE_WIDTH-1:0] line_in,
    input  logic [BIN_WIDTH-1:0]  carry_in,
    output logic [LINE_WIDTH-1:0] cdf_line,
    output logic [BIN_WIDTH-1:0]  carry_out
);

    logic [BIN_WIDTH-1:0] c0, c1, c2, c3;

    // Chained 32-bit adds, wrapping modulo 2^32.
    always_comb begin
        c0        = carry_in + line_in[BIN0_MSB:BIN0_LSB];
        c1        = c0 + line_in[BIN1_MSB:BIN1_LSB];
        c2        = c1 + line_in[BIN2_MSB:BIN2_LSB];
        c3        = c2 + line_in[BIN3_MSB:BIN3_LSB];
        cdf_line  = {c0, c1, c2, c3};
        carry_out = c3;
    end

endmodule

// File: rtl/histogram_cdf_writer.sv
// Reads the histogram scratch lines in order, writes the cumulative
// distribution to output memory and reports the final total.
module histogram_cdf_writer #(
    parameter int unsigned NUM_LINES        = histogram_pkg::NUM_LINES,
    parameter logic [15:0] OUT_BASE_ADDRESS = 16'd0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    histogram_cdf_writer_if.master mem,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            total_count
);
    import histogram_pkg::*;

    localparam logic [15:0] LAST_ADDRESS = 16'(NUM_LINES - 1);

    cdf_state_t            state;
    logic                  rd_valid;
    logic [15:0]           wr_index;
    logic [BIN_WIDTH-1:0]  run;
    logic [LINE_WIDTH-1:0] cdf_line;
    logic [BIN_WIDTH-1:0]  carry_out;

    histogram_line_prefix_sum u_prefix_sum (
        .line_in   (mem.scratch_memory_rdata),
        .carry_in  (run),
        .cdf_line  (cdf_line),
        .carry_out (carry_out)
    );

    // Control FSM plus the registered prefix-sum write stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                              <= ST_IDLE;
            rd_valid                           <= 1'b0;
            wr_index                           <= '0;
            run                                <= '0;
            busy                               <= 1'b0;
            done                               <= 1'b0;
            total_count                        <= '0;
            mem.scratch_memory_address_pointer <= '0;
            mem.output_memory_write_enable     <= 1'b0;
            mem.output_memory_address          <= '0;
            mem.output_memory_wdata            <= '0;
        end else begin
            done                           <= 1'b0;
            mem.output_memory_write_enable <= 1'b0;
            // Read data lags the address by one cycle.
            rd_valid                       <= (state == ST_READ);

            if (rd_valid) begin
                mem.output_memory_write_enable <= 1'b1;
                mem.output_memory_wdata        <= cdf_line;
                mem.output_memory_address      <= OUT_BASE_ADDRESS + wr_index;
                wr_index                       <= wr_index + 16'd1;
                run                            <= carry_out;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state                              <= ST_READ;
                        mem.scratch_memory_address_pointer <= '0;
                        run                                <= '0;
                        wr_index                           <= '0;
                        total_count                        <= '0;
                        busy                               <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (mem.scratch_memory_address_pointer == LAST_ADDRESS) begin
                        state <= ST_DRAIN;
                    end else begin
                        mem.scratch_memory_address_pointer <=
                            mem.scratch_memory_address_pointer + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    // The final line has been summed once rd_valid drops; its
                    // write is registered this same cycle.
                    if (!rd_valid) begin
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        total_count <= run;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_cdf_writer.sv
// Directed bench for histogram_cdf_writer with a one-cycle-latency scratch
// memory model and a negedge monitor logging writes and done pulses.
module tb_histogram_cdf_writer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] total_count;

    histogram_cdf_writer_if mem_if ();

    histogram_cdf_writer #(
        .NUM_LINES        (64),
        .OUT_BASE_ADDRESS (16'd0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mem         (mem_if.master),
        .busy        (busy),
        .done        (done),
        .total_count (total_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [127:0] smem [64];
    int           cyc;

    always @(posedge clock) begin
        mem_if.scratch_memory_rdata <= smem[mem_if.scratch_memory_address_pointer[5:0]];
        cyc <= cyc + 1;
    end

    logic [127:0] wr_data [128];
    logic [15:0]  wr_addr [128];
    int           wr_cyc  [128];
    int           wr_cnt;
    int           done_cnt;
    int           done_cyc;
    int           busy_cnt;
    logic [31:0]  total_at_done;

    always @(negedge clock) begin
        if (mem_if.output_memory_write_enable) begin
            if (wr_cnt < 128) begin
                wr_data[wr_cnt] = mem_if.output_memory_wdata;
                wr_addr[wr_cnt] = mem_if.output_memory_address;
                wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done) begin
            done_cnt      = done_cnt + 1;
            done_cyc      = cyc;
            total_at_done = total_count;
        end
        if (busy) busy_cnt = busy_cnt + 1;
    end

    int total;
    int bad;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic fill_mem(input int id);
        for (int k = 0; k < 64; k++) begin
            case (id)
                2:       smem[k] = {32'd1, 32'd1, 32'd1, 32'd1};
                default: smem[k] = '0;
            endcase
        end
        if (id == 1) smem[0] = {32'd1, 96'd0};
        if (id == 3) smem[0] = {32'hFFFFFFFF, 32'd2, 64'd0};
    endtask

    // Hand-derived closed forms for each data pattern.
    function automatic logic [127:0] exp_line(input int id, input int k);
        logic [127:0] v;
        case (id)
            1:       v = {32'd1, 32'd1, 32'd1, 32'd1};
            2:       v = {32'(4*k+1), 32'(4*k+2), 32'(4*k+3), 32'(4*k+4)};
            3:       v = (k == 0) ? {32'hFFFFFFFF, 32'd1, 32'd1, 32'd1}
                                  : {32'd1, 32'd1, 32'd1, 32'd1};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic clear_log();
        wr_cnt   = 0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            wr_data[i] = {4{32'hDEADBEEF}};
            wr_addr[i] = 16'hBEEF;
            wr_cyc[i]  = -1;
        end
    endtask

    task automatic run_and_check(input int id, input logic [31:0] exp_total, input bit stray);
        int t0;
        clear_log();
        tick();
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && done_cnt == 0; i++) begin
            tick();
            start = (stray && (cyc == t0 + 10 || cyc == t0 + 40)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_value("done_count", 128'(done_cnt), 128'd1);
        check_value("done_latency", 128'(done_cyc - t0), 128'd67);
        check_value("write_count", 128'(wr_cnt), 128'd64);
        check_value("busy_cycles", 128'(busy_cnt), 128'd66);
        check_value("total_at_done", 128'(total_at_done), 128'(exp_total));
        check_value("total_held", 128'(total_count), 128'(exp_total));
        check_value("first_write_cycle", 128'(wr_cyc[0] - t0), 128'd3);
        check_value("last_write_cycle", 128'(wr_cyc[63] - t0), 128'd66);
        for (int k = 0; k < 64; k++) begin
            check_value($sformatf("line%0d_id%0d", k, id), wr_data[k], exp_line(id, k));
            check_value($sformatf("addr%0d", k), 128'(wr_addr[k]), 128'(k));
        end
        check_value("scratch_addr_hold", 128'(mem_if.scratch_memory_address_pointer), 128'd63);
        check_value("out_addr_hold", 128'(mem_if.output_memory_address), 128'd63);
        check_value("wdata_hold", mem_if.output_memory_wdata, exp_line(id, 63));
        check_value("we_idle", 128'(mem_if.output_memory_write_enable), 128'd0);
        check_value("busy_idle", 128'(busy), 128'd0);
    endtask

    initial begin
        int t0;
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b1;
        start = 1'b1;
        fill_mem(0);
        clear_log();
        repeat (3) tick();
        start = 1'b0;
        tick();
        reset = 1'b0;

        check_value("rst_busy", 128'(busy), 128'd0);
        check_value("rst_done", 128'(done), 128'd0);
        check_value("rst_total", 128'(total_count), 128'd0);
        check_value("rst_we", 128'(mem_if.output_memory_write_enable), 128'd0);
        check_value("rst_out_addr", 128'(mem_if.output_memory_address), 128'd0);
        check_value("rst_wdata", mem_if.output_memory_wdata, 128'd0);
        check_value("rst_scratch_addr", 128'(mem_if.scratch_memory_address_pointer), 128'd0);
        check_value("rst_no_writes", 128'(wr_cnt), 128'd0);

        fill_mem(0); run_and_check(0, 32'd0, 1'b0);
        fill_mem(2); run_and_check(2, 32'd256, 1'b0);
        fill_mem(1); run_and_check(1, 32'd1, 1'b0);
        fill_mem(3); run_and_check(3, 32'd1, 1'b0);

        // Reset asserted in T20 of a pass.
        fill_mem(2);
        clear_log();
        tick();
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && cyc < t0 + 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("midrst_busy", 128'(busy), 128'd0);
        check_value("midrst_we", 128'(mem_if.output_memory_write_enable), 128'd0);
        check_value("midrst_done", 128'(done), 128'd0);
        repeat (80) tick();
        check_value("midrst_writes", 128'(wr_cnt), 128'd18);
        check_value("midrst_no_done", 128'(done_cnt), 128'd0);
        check_value("midrst_total", 128'(total_count), 128'd0);
        run_and_check(2, 32'd256, 1'b0);

        // Stray starts at T10 and T40 must be ignored.
        fill_mem(1); run_and_check(1, 32'd1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
